serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
//
// PURPOSE
//   Bit-serial unsigned subtractor: the inverse arithmetic direction of the
//   combinational half adder. Accepts two WIDTH-bit operands with a
//   valid/ready handshake and computes DIFF = A - B, LSB first, one bit per
//   clock, using a single full-subtractor cell and a borrow flop.
//   Returns DIFF and final BORROW on a valid/ready output handshake.
//   Used where area matters more than latency in the arithmetic trainee datapath.
//
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 2..32
//
// PORTS
//   CLK        in   1      rising-edge clock
//   RST_N      in   1      asynchronous active-low reset
//   IN_VALID   in   1      operands A/B valid
//   IN_READY   out  1      block can accept operands (high only in IDLE)
//   A          in   WIDTH  minuend, unsigned
//   B          in   WIDTH  subtrahend, unsigned
//   OUT_VALID  out  1      DIFF/BORROW valid (high only in DONE)
//   OUT_READY  in   1      consumer accepts result
//   DIFF       out  WIDTH  (A - B) mod 2**WIDTH
//   BORROW     out  1      1 when A < B (unsigned)
//   BUSY       out  1      high in RUN and DONE
//
// BEHAVIOUR
// - Reset (RST_N low, async): state=IDLE, shift regs/count/borrow=0;
//   outputs IN_READY=1, OUT_VALID=0, DIFF=0, BORROW=0, BUSY=0.
// - FSM states: IDLE, RUN, DONE.
// - IDLE: IN_READY=1. Accept on IN_VALID&&IN_READY at a rising edge (edge k).
//   On accept: latch A, B into shift regs; borrow=0; cnt=0; go to RUN.
// - RUN: each cycle uses a=a_sr[0], b=b_sr[0], br=borrow:
//   d = a^b^br;  br' = (~a&b) | (~(a^b)&br).
//   d shifts into the MSB of res_sr; a_sr and b_sr shift right; cnt++.
// - RUN exit: when cnt==WIDTH-1, go to DONE. BORROW register takes br'.
// - Timing: exactly WIDTH cycles in RUN. OUT_VALID rises after edge k+WIDTH.
// - DONE: OUT_VALID=1. DIFF=res_sr and BORROW are stable until handshake.
//   On OUT_READY=1 at an edge: go to IDLE. DIFF/BORROW keep their last
//   values after DONE; they are meaningful only while OUT_VALID=1.
// - Backpressure: OUT_READY low holds DONE indefinitely; no data change.
// - A/B/IN_VALID are ignored outside IDLE. Operands change during RUN -> no effect.
// - OUT_READY is ignored outside DONE.
// - DONE with OUT_READY and IN_VALID both high: return to IDLE without
//   accepting. Earliest next accept is the following edge, so throughput is
//   one operation per WIDTH+2 cycles minimum.
// - Reset mid-RUN/DONE: immediate async return to reset values.
//   The partial result is discarded and no OUT_VALID is produced.
// - Arithmetic: DIFF is a modulo-2**WIDTH result. BORROW is the final borrow
//   and equals (A < B). A==B gives DIFF=0, BORROW=0.
//
// TESTING (WIDTH=8 unless noted)
// - A=100,B=37, OUT_READY=1 -> OUT_VALID 8 cycles after accept, DIFF=63,
//   BORROW=0. IN_READY=0 for the whole operation.
// - A=5,B=9 -> DIFF=252, BORROW=1. A=0,B=255 -> DIFF=1, BORROW=1.
//   A=255,B=255 -> DIFF=0, BORROW=0.
// - OUT_READY low for 5 cycles in DONE -> OUT_VALID, DIFF, BORROW held
//   constant. IDLE the cycle after OUT_READY is raised.
// - IN_VALID held high with A/B changing every cycle during RUN -> result
//   matches the operands latched at accept only. No second accept until IDLE.
// - RST_N pulsed low at RUN cycle 3 -> all outputs at reset values
//   immediately. A new A=10,B=3 after release gives DIFF=7, BORROW=0.
// - WIDTH=2, exhaustive 16 operand pairs back-to-back -> each DIFF/BORROW
//   matches the reference model. Spacing between accepts is 4 cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, WIDTH cycles per operation behind valid/ready handshakes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [WIDTH-1:0] r_a_sr, r_b_sr, r_res_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             w_accept, w_last, w_d, w_br_nxt;

    assign w_accept = i_in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Full-subtractor cell on the current LSBs and the running borrow.
    assign w_d      = r_a_sr[0] ^ r_b_sr[0] ^ r_br;
    assign w_br_nxt = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_br);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                if (i_out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The borrow flop doubles as the BORROW output: after the last RUN cycle
    // it holds the final borrow and stays put until the next accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
        end else if (w_accept) begin
            r_a_sr <= i_a;
            r_b_sr <= i_b;
            r_br   <= 1'b0;
            r_cnt  <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_res_sr <= {w_d, r_res_sr[WIDTH-1:1]};
            r_br     <= w_br_nxt;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_diff   = r_res_sr;
    assign o_borrow = r_br;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 scenarios plus an exhaustive
// back-to-back sweep on a WIDTH=2 instance.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;

    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, borrow, busy;
    logic [7:0] diff;

    logic       in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic [1:0] a2 = '0, b2 = '0;
    logic       in_ready2, out_valid2, borrow2, busy2;
    logic [1:0] diff2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_a(a), .i_b(b), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_diff(diff), .o_borrow(borrow), .o_busy(busy)
    );

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid2), .o_in_ready(in_ready2),
        .i_a(a2), .i_b(b2), .o_out_valid(out_valid2), .i_out_ready(out_ready2),
        .o_diff(diff2), .o_borrow(borrow2), .o_busy(busy2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Waits for OUT_VALID; lat counts edges after the accept edge.
    task automatic wait_done(output int lat, output bit rdy_seen, input bit scramble);
        lat = 0;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_seen = 1'b1;
            if (scramble) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            tick();
            lat++;
        end
    endtask

    task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic [7:0] ed, input logic eb);
        int lat;
        bit rs;
        in_valid = 1'b1; a = ta; b = tb_;
        tick();
        in_valid = 1'b0;
        wait_done(lat, rs, 1'b0);
        chk({tag, "_lat"}, 32'(lat), 32'd8);
        chk({tag, "_rdy_low"}, 32'(rs), 32'd0);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, acc, prev, idx, g;
        bit rs;

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #11 rst_n = 1'b1;
        tick();

        op("a100b37", 8'd100, 8'd37, 8'd63, 1'b0);
        op("a5b9", 8'd5, 8'd9, 8'd252, 1'b1);
        op("a0b255", 8'd0, 8'd255, 8'd1, 1'b1);
        op("a255b255", 8'd255, 8'd255, 8'd0, 1'b0);

        // Backpressure: result held for 5 cycles with OUT_READY low.
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'd200; b = 8'd50;
        tick();
        in_valid = 1'b0;
        wait_done(lat, rs, 1'b0);
        chk("bp_lat", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_diff", 32'(diff), 32'd150);
            chk("bp_borrow", 32'(borrow), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_vld", 32'(out_valid), 32'd0);
        chk("bp_release_idle", 32'(in_ready), 32'd1);

        // Operands churn during RUN with IN_VALID held high.
        in_valid = 1'b1; a = 8'd77; b = 8'd100;
        tick();
        wait_done(lat, rs, 1'b1);
        chk("churn_lat", 32'(lat), 32'd8);
        chk("churn_rdy_low", 32'(rs), 32'd0);
        chk("churn_diff", 32'(diff), 32'd233);
        chk("churn_borrow", 32'(borrow), 32'd1);
        tick();
        chk("churn_no_accept_busy", 32'(busy), 32'd0);
        chk("churn_no_accept_rdy", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick();

        // Async reset in the middle of RUN.
        in_valid = 1'b1; a = 8'd50; b = 8'd20;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_borrow", 32'(borrow), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_no_valid", 32'(out_valid), 32'd0);
        op("a10b3", 8'd10, 8'd3, 8'd7, 1'b0);

        // WIDTH=2 exhaustive sweep, back-to-back.
        out_ready2 = 1'b1;
        prev = 0;
        idx = 0;
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                g = 0;
                while (!in_ready2 && g < 20) begin
                    tick();
                    g++;
                end
                a2 = 2'(ia); b2 = 2'(ib); in_valid2 = 1'b1;
                tick();
                acc = cyc;
                if (idx > 0) chk("w2_spacing", 32'(acc - prev), 32'd4);
                prev = acc;
                idx++;
                g = 0;
                while (!out_valid2 && g < 20) begin
                    tick();
                    g++;
                end
                chk("w2_lat", 32'(g), 32'd2);
                chk("w2_diff", 32'(diff2), 32'((ia - ib) & 3));
                chk("w2_borrow", 32'(borrow2), 32'(ia < ib));
            end
        end
        in_valid2 = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
